// File: rtl/y86_mem_pkg.sv
// Shared constants and helpers for the y86 memory subsystem: I/O page
// register offsets, STATUS register bit positions and the page-match test.
package y86_mem_pkg;

    localparam logic [7:0] TXDATA_OFS = 8'h00;
    localparam logic [7:0] STATUS_OFS = 8'h04;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_COUNT_LSB = 3;
    localparam int ST_COUNT_W   = 5;

    // True when addr lies in the 256-byte page starting at base.
    function automatic logic io_page_hit(input logic [31:0] addr, input logic [31:0] base);
        return ((addr ^ base) & 32'hFFFF_FF00) == 32'h0;
    endfunction

endpackage

// File: rtl/y86_mem_sys_if.sv
// Core-side bus of the y86 sequential core: byte address, store data,
// store/read strobes and combinational read data.
interface y86_mem_sys_if;
    logic [31:0] bus_A;
    logic [31:0] bus_out;
    logic        bus_WE;
    logic        bus_RE;
    logic [31:0] bus_in;

    modport master (output bus_A, output bus_out, output bus_WE, output bus_RE, input bus_in);
    modport slave  (input bus_A, input bus_out, input bus_WE, input bus_RE, output bus_in);
endinterface

// File: rtl/y86_tx_fifo.sv
// Byte transmit FIFO draining over a valid/ready stream. A push into a full
// FIFO is still accepted when the head leaves in the same cycle; otherwise it
// is dropped and the sticky overflow flag is raised until cleared.
module y86_tx_fifo import y86_mem_pkg::*; #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [7:0]                  push_data,
    input  logic                        clr_ovf,
    input  logic                        tx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       buf_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop;
    logic             push_ok;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign tx_valid = !empty;
    assign pop      = tx_valid && tx_ready;
    assign push_ok  = push && (!full || pop);
    // Head is forced to zero when empty so stale storage never leaks out.
    assign tx_data  = empty ? 8'h00 : buf_q[rd_ptr];

    // Entry storage; not reset, occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) buf_q[wr_ptr] <= push_data;
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            if (clr_ovf)
                overflow <= 1'b0;
            else if (push && !push_ok)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/y86_mem_sys.sv
// Memory subsystem behind the y86 core bus. A four-bank byte RAM serves
// unaligned little-endian 32-bit accesses in one cycle (each bank supplies one
// byte lane); an I/O page exposes a TX FIFO and its STATUS register.
module y86_mem_sys import y86_mem_pkg::*; #(
    parameter int          ADDR_W     = 12,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
    input  logic              clk,
    input  logic              rst_n,
    y86_mem_sys_if.slave      bus,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_byte,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_overflow
);
    localparam int ROW_W = ADDR_W - 2;
    localparam int ROWS  = 1 << ROW_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // mem[b][r] holds byte address {r, b}.
    logic [7:0]        mem [4][ROWS];

    logic              io_hit;
    logic [7:0]        io_ofs;
    logic [ADDR_W-1:0] a_ram;
    logic [1:0]        lane [4];
    logic [ROW_W-1:0]  row  [4];
    logic [7:0]        rd_byte [4];
    logic [31:0]       ram_word;
    logic [31:0]       status_word;
    logic              ram_we;
    logic              fifo_push;
    logic              fifo_clr_ovf;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_ovf;

    assign io_hit       = io_page_hit(bus.bus_A, IO_BASE);
    assign io_ofs       = bus.bus_A[7:0];
    assign a_ram        = bus.bus_A[ADDR_W-1:0];
    assign ram_we       = bus.bus_WE && !io_hit;
    assign fifo_push    = bus.bus_WE && io_hit && (io_ofs == TXDATA_OFS);
    assign fifo_clr_ovf = bus.bus_WE && io_hit && (io_ofs == STATUS_OFS);
    assign tx_overflow  = fifo_ovf;

    // For each bank: which byte lane of the word it carries and which row it
    // touches. Lanes past the end of a row spill into the next row, and the
    // ADDR_W-bit sum gives the wrap at the top of RAM for free.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            lane[b]    = 2'(b) - a_ram[1:0];
            row[b]     = ROW_W'((a_ram + ADDR_W'(lane[b])) >> 2);
            rd_byte[b] = mem[b][row[b]];
        end
    end

    // Reassemble the little-endian word: lane j comes from bank (a + j) mod 4.
    always_comb begin
        ram_word = '0;
        for (int j = 0; j < 4; j++) begin
            ram_word[8*j +: 8] = rd_byte[2'(j) + a_ram[1:0]];
        end
    end

    // STATUS register image from current (pre-edge) FIFO state.
    always_comb begin
        status_word                                = '0;
        status_word[ST_EMPTY_BIT]                  = fifo_empty;
        status_word[ST_FULL_BIT]                   = fifo_full;
        status_word[ST_OVF_BIT]                    = fifo_ovf;
        status_word[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
    end

    // Read mux: RAM outside the I/O page, STATUS inside, zero otherwise.
    always_comb begin
        bus.bus_in = '0;
        if (bus.bus_RE) begin
            if (!io_hit)
                bus.bus_in = ram_word;
            else if (io_ofs == STATUS_OFS)
                bus.bus_in = status_word;
        end
    end

    // Store and preload writes. The preload write is issued last so that it
    // overrides the store on a shared byte while the store's other bytes land.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                mem[b][row[b]] <= bus.bus_out[8*lane[b] +: 8];
            end
        end
        if (ld_we) mem[ld_addr[1:0]][ld_addr[ADDR_W-1:2]] <= ld_byte;
    end

    y86_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (bus.bus_out[7:0]),
        .clr_ovf   (fifo_clr_ovf),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_ovf)
    );

endmodule

// File: tb/tb_y86_mem_sys.sv
// Bench for y86_mem_sys: directed vectors with literal expectations plus a
// byte-array / queue reference model compared against the DUT every cycle.
module tb_y86_mem_sys;
    localparam int          AW       = 12;
    localparam int          RAM_SIZE = 1 << AW;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] IO_BASE  = 32'hFFFF_FF00;
    localparam logic [31:0] TXDATA_A = IO_BASE + 32'h0;
    localparam logic [31:0] STATUS_A = IO_BASE + 32'h4;
    localparam logic [31:0] OTHER_A  = IO_BASE + 32'h8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_byte;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_overflow;

    y86_mem_sys_if bus_if ();

    y86_mem_sys #(
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH),
        .IO_BASE    (IO_BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_byte     (ld_byte),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Reference model: RAM bytes with a written-yet flag, FIFO as a queue.
    logic [7:0] m_ram   [RAM_SIZE];
    bit         m_known [RAM_SIZE];
    logic [7:0] m_q [$];
    bit         m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_io(input logic [31:0] a);
        return (a & 32'hFFFF_FF00) == IO_BASE;
    endfunction

    // Apply one clock edge of architectural behaviour to the model.
    function automatic void model_edge();
        bit         pop;
        logic [7:0] ofs;
        int         a;
        ofs = bus_if.bus_A[7:0];
        pop = (m_q.size() > 0) && tx_ready;
        if (bus_if.bus_WE && !is_io(bus_if.bus_A)) begin
            for (int k = 0; k < 4; k++) begin
                a = (int'(bus_if.bus_A[AW-1:0]) + k) % RAM_SIZE;
                m_ram[a]   = bus_if.bus_out[8*k +: 8];
                m_known[a] = 1'b1;
            end
        end
        if (ld_we) begin
            m_ram[ld_addr]   = ld_byte;
            m_known[ld_addr] = 1'b1;
        end
        if (bus_if.bus_WE && is_io(bus_if.bus_A) && ofs == 8'h04) m_ovf = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (bus_if.bus_WE && is_io(bus_if.bus_A) && ofs == 8'h00) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus_if.bus_out[7:0]);
            else m_ovf = 1'b1;
        end
    endfunction

    // Expected bus_in; returns 0 when it depends on never-written RAM bytes.
    function automatic bit model_bus_in(output logic [31:0] v);
        int a;
        v = '0;
        if (!bus_if.bus_RE) return 1'b1;
        if (is_io(bus_if.bus_A)) begin
            if (bus_if.bus_A[7:0] == 8'h04)
                v = {24'b0, 5'(m_q.size()), m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
            return 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            a = (int'(bus_if.bus_A[AW-1:0]) + k) % RAM_SIZE;
            if (!m_known[a]) return 1'b0;
            v[8*k +: 8] = m_ram[a];
        end
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                model_edge();
            end
        end
    end

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("model_tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
                check("model_tx_data", 32'(tx_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
                check("model_tx_overflow", 32'(tx_overflow), 32'(m_ovf));
                if (model_bus_in(e)) check("model_bus_in", bus_if.bus_in, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_if.bus_RE  = re;
        bus_if.bus_WE  = we;
        bus_if.bus_A   = a;
        bus_if.bus_out = d;
    endtask

    initial begin
        ld_we = 1'b0; ld_addr = '0; ld_byte = '0; tx_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_overflow", 32'(tx_overflow), 32'h0);
        check("rst_bus_in_idle", bus_if.bus_in, 32'h0);
        drive(1'b1, 1'b0, STATUS_A, 32'h0);
        #1 check("rst_status", bus_if.bus_in, 32'h0000_0001);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Preload 0x10..0x17 with 0xA0..0xA7, then unaligned read.
        for (int i = 0; i < 8; i++) begin
            ld_we = 1'b1; ld_addr = AW'(16 + i); ld_byte = 8'(8'hA0 + i);
            step();
        end
        ld_we = 1'b0;
        drive(1'b1, 1'b0, 32'h11, 32'h0);
        @(negedge clk) check("rd_unaligned", bus_if.bus_in, 32'hA4A3A2A1);

        step();
        drive(1'b0, 1'b1, 32'h13, 32'hDEADBEEF);
        step();
        drive(1'b1, 1'b0, 32'h13, 32'h0);
        @(negedge clk) check("rd_after_store", bus_if.bus_in, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1 check("rd_neighbour_kept", bus_if.bus_in, 32'hEFA2A1A0);

        // Store and preload colliding on byte 0x21: preload wins that byte.
        step();
        drive(1'b0, 1'b1, 32'h20, 32'h01020304);
        ld_we = 1'b1; ld_addr = AW'(12'h021); ld_byte = 8'h99;
        step();
        ld_we = 1'b0;
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk) check("preload_wins", bus_if.bus_in, 32'h01029904);

        // Wrap at the top of RAM.
        step();
        drive(1'b0, 1'b1, 32'h0000_0FFE, 32'h11223344);
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk) check("wrap_low_half", {16'h0, bus_if.bus_in[15:0]}, 32'h0000_1122);
        drive(1'b1, 1'b0, 32'h0000_0FFE, 32'h0);
        #1 check("wrap_word", bus_if.bus_in, 32'h11223344);
        drive(1'b1, 1'b0, 32'h0000_1FFE, 32'h0);
        #1 check("alias_word", bus_if.bus_in, 32'h11223344);

        // FIFO ordering and handshake.
        step();
        drive(1'b0, 1'b1, TXDATA_A, 32'h41);
        @(negedge clk) check("valid_before_push", 32'(tx_valid), 32'h0);
        step();
        drive(1'b0, 1'b1, TXDATA_A, 32'h42);
        @(negedge clk) check("valid_after_push", 32'(tx_valid), 32'h1);
        check("head_after_push", 32'(tx_data), 32'h41);
        step();
        drive(1'b0, 1'b1, TXDATA_A, 32'h43);
        step();
        drive(1'b1, 1'b0, TXDATA_A, 32'h0);
        @(negedge clk) check("rd_txdata_zero", bus_if.bus_in, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tx_ready = 1'b1;
        #1 check("drain_0", 32'(tx_data), 32'h41);
        step();
        @(negedge clk) check("drain_1", 32'(tx_data), 32'h42);
        step();
        @(negedge clk) check("drain_2", 32'(tx_data), 32'h43);
        step();
        @(negedge clk) check("drain_done", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Overflow: nine pushes into a depth-8 FIFO.
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, TXDATA_A, 32'(8'h60 + i));
            step();
        end
        drive(1'b1, 1'b0, STATUS_A, 32'h0);
        @(negedge clk) check("ovf_status", bus_if.bus_in, 32'h0000_0046);
        check("ovf_flag", 32'(tx_overflow), 32'h1);
        check("ovf_head", 32'(tx_data), 32'h60);
        step();
        drive(1'b0, 1'b1, STATUS_A, 32'h0);
        step();
        drive(1'b1, 1'b0, STATUS_A, 32'h0);
        @(negedge clk) check("ovf_cleared", 32'(tx_overflow), 32'h0);
        check("status_full_no_ovf", bus_if.bus_in, 32'h0000_0042);

        // Unused I/O offset: write ignored, read zero.
        step();
        drive(1'b0, 1'b1, OTHER_A, 32'h77);
        step();
        drive(1'b1, 1'b0, OTHER_A, 32'h0);
        @(negedge clk) check("rd_other_ofs", bus_if.bus_in, 32'h0);

        // Full FIFO, push and pop in the same cycle.
        step();
        tx_ready = 1'b1;
        drive(1'b0, 1'b1, TXDATA_A, 32'h55);
        step();
        tx_ready = 1'b0;
        drive(1'b1, 1'b0, STATUS_A, 32'h0);
        @(negedge clk) check("full_pushpop_status", bus_if.bus_in, 32'h0000_0042);
        check("full_pushpop_ovf", 32'(tx_overflow), 32'h0);
        check("full_pushpop_head", 32'(tx_data), 32'h61);

        // Drain everything, then queue three bytes and reset between edges.
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tx_ready = 1'b1;
        repeat (8) step();
        tx_ready = 1'b0;
        @(negedge clk) check("drained_all", 32'(tx_valid), 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, TXDATA_A, 32'(8'h31 + i));
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk) check("queued_before_rst", 32'(tx_valid), 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async_valid", 32'(tx_valid), 32'h0);
        check("rst_async_data", 32'(tx_data), 32'h0);
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b0, STATUS_A, 32'h0);
        @(negedge clk) check("status_after_rst", bus_if.bus_in, 32'h0000_0001);
        step();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1 check("ram_after_rst", bus_if.bus_in, 32'hEFA2A1A0);

        step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/y86_mem_sys.md
# y86_mem_sys

Memory subsystem downstream of the y86 sequential core's bus port (`bus_A`, `bus_out`, `bus_WE`, `bus_RE`, `bus_in`). It serves byte-addressed, unaligned, little-endian 32-bit instruction fetches, loads and stores from a local RAM. It also decodes a memory-mapped I/O page holding a byte transmit FIFO that drains over a valid/ready stream. A side-band preload port fills the RAM with a program before the core leaves reset.

## Interface
- `ADDR_W`, default 12: RAM size is 2^ADDR_W bytes; byte addresses wrap modulo this size.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two, at least 2.
- `IO_BASE`, default 32'hFFFF_FF00: base of the 256-byte I/O page; bits [7:0] must be 0.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bus_A`  in  32  byte address from the core.
- `bus_out`  in  32  store data from the core.
- `bus_WE`  in  1  store strobe, one cycle.
- `bus_RE`  in  1  read strobe (fetch or load).
- `bus_in`  out  32  read data to the core, combinational.
- `ld_we`  in  1  preload byte write.
- `ld_addr`  in  ADDR_W  preload byte address.
- `ld_byte`  in  8  preload data.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts head.
- `tx_overflow`  out  1  sticky flag: a push was dropped.

## Operation
- I/O hit: `bus_A[31:8] == IO_BASE[31:8]`. Every other address maps to RAM byte `bus_A[ADDR_W-1:0]`.
- RAM read, with `bus_RE` high and no I/O hit: `bus_in = {m[a+3], m[a+2], m[a+1], m[a]}`. Each `a+k` is taken modulo 2^ADDR_W.
- `bus_in` is 0 whenever `bus_RE` is low.
- RAM write, with `bus_WE` high and no I/O hit: bytes `bus_out[7:0]` through `bus_out[31:24]` go to `a` through `a+3`, little-endian, with wrap.
- Preload: `ld_we` writes `ld_byte` to `m[ld_addr]`. If preload and a core store hit the same byte in the same cycle, the preload wins. Other bytes of that store still write.
- RAM contents are not reset.
- I/O offset 0x00, TXDATA:
  - Write pushes `bus_out[7:0]`.
  - Read returns 0.
- I/O offset 0x04, STATUS:
  - Read returns `{24'b0, count[4:0], overflow, full, empty}`, with `empty` at bit 0.
  - Any write clears `overflow`.
- Other I/O offsets read 0; writes to them are ignored.
- Push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise the byte is dropped and `overflow` is set.
- Pop happens on `tx_valid && tx_ready`. `tx_data` is the head entry and is 0 when the FIFO is empty.
- `tx_overflow` mirrors the internal `overflow` flag.

## Timing
- Reads have zero latency: `bus_in` is combinational from `bus_A`, `bus_RE`, RAM and FIFO state. The core captures it on the same edge.
- A RAM store is visible to a read on the cycle after the store's edge.
- A pushed byte appears on `tx_data`/`tx_valid` one cycle after the push edge.
- A STATUS read returns state as of before the current edge.
- Pointers use FIFO_DEPTH-wrap arithmetic; count ranges 0 to FIFO_DEPTH.
- Reset (asynchronous): FIFO empty, pointers 0, `overflow` 0, `tx_valid` 0, `tx_data` 0. `bus_in` is 0 while `bus_RE` is low.
- When `rst_n` is asserted mid-drain, queued bytes are discarded immediately and `tx_valid` falls without waiting for a clock.

## Structure
- Package `y86_mem_pkg` holds:
  - offset constants `TXDATA_OFS` (0x00) and `STATUS_OFS` (0x04);
  - STATUS bit-index constants;
  - the I/O page-match helper function.
- Sub-module `y86_tx_fifo` holds the FIFO:
  - parameter FIFO_DEPTH;
  - push/pop/data ports;
  - full, empty, count and overflow outputs.
- The top level holds the four-bank RAM, address decode and read mux.

## Test plan
- Unaligned write and read:
  - Preload bytes 0x10..0x17 with 0xA0..0xA7.
  - Read at 0x11 → `bus_in` = 0xA4A3A2A1.
  - Store 0xDEADBEEF at 0x13, then read 0x13 on the next cycle → 0xDEADBEEF, and byte 0x12 is still 0xA2.
- Wrap: store 0x11223344 at 0xFFE (ADDR_W=12), read at 0x000 → low half 0x1122, i.e. bytes m[0]=0x22 and m[1]=0x11.
- FIFO order and handshake:
  - Push 0x41, 0x42, 0x43 with `tx_ready`=0; `tx_valid` rises on the cycle after the first push.
  - Raise `tx_ready` → 0x41, 0x42, 0x43 drained on consecutive cycles, then `tx_valid` = 0.
- Overflow:
  - Push 9 bytes with `tx_ready`=0 (depth 8) → 9th byte dropped, `tx_overflow`=1, STATUS = 0x00000046.
  - Write STATUS → `tx_overflow`=0.
- Full with simultaneous push and pop: FIFO full, `tx_ready`=1, push 0x55 → accepted, count stays 8, `tx_overflow` stays 0.
- Reset mid-operation: 3 bytes queued, pulse `rst_n` low between edges → `tx_valid`=0 immediately, STATUS = 0x00000001 after release, RAM contents unchanged.
